tracking_iq_collector: RTL and testbench
========================================

Name: tracking_iq_collector

Overview:
- Upstream feeder of tracking_iq_fifo.
- Captures per-channel early/prompt/late I/Q accumulation dumps from N tracking channels and holds each in a per-channel slot.
- Round-robin arbitrates pending slots and writes one tagged 108-bit word per cycle into the FIFO.
- The FIFO exposes no full flag, so this block tracks FIFO occupancy with a credit counter, snooping the consumer's rdreq/empty.

Parameters:
N_CHANNELS, 8, number of tracking channels (1..64)
ACC_WIDTH, 17, width of each accumulation field
CHAN_WIDTH, 6, channel tag width
WIDTH, 108, FIFO word width; must equal CHAN_WIDTH+6*ACC_WIDTH
DEPTH, 4, FIFO depth in words; initial credit count

Ports:
clock  in  1  system clock, all logic rising-edge
reset_n  in  1  synchronous active-low reset
clear  in  1  synchronous soft clear (tracking restart)
acc_valid  in  N_CHANNELS  one-cycle dump strobe per channel
acc_data  in  N_CHANNELS*6*ACC_WIDTH  per channel {ie,ip,il,qe,qp,ql}, channel 0 in LSBs
fifo_rdreq  in  1  consumer's rdreq to FIFO (snooped)
fifo_empty  in  1  FIFO empty flag
fifo_wrreq  out  1  FIFO write strobe, registered
fifo_data  out  WIDTH  {chan[CHAN_WIDTH-1:0], ie,ip,il,qe,qp,ql}, registered
fifo_sclr  out  1  FIFO synchronous clear, registered
pending  out  N_CHANNELS  slot-occupied flags
overflow  out  N_CHANNELS  sticky dropped-dump flags

Behaviour:
- Reset (reset_n=0 at an edge):
  - pending, overflow, fifo_wrreq and fifo_data are 0.
  - credits = DEPTH; RR pointer = N_CHANNELS-1 (channel 0 wins first).
  - fifo_sclr = 1 during the cycle after every reset edge.
- clear=1 has the same effect as reset, including fifo_sclr=1 the next cycle. clear overrides every other event that cycle.
- Capture:
  - acc_valid[c] with pending[c]=0: latch the slot and set pending[c].
  - acc_valid[c] with pending[c]=1 and slot c not granted that cycle: keep the old data, drop the new, set overflow[c].
  - acc_valid[c] in the same cycle slot c is granted: latch the new data, pending[c] stays 1, no overflow.
- Arbitration (combinational, per cycle):
  - Eligible only if credits>0 (registered value; no same-cycle bypass from fifo_rdreq).
  - Grant goes to the first pending channel searching from RR pointer+1 upward, with wrap-around.
  - On grant at an edge: fifo_data <= {c, slot c}; fifo_wrreq <= 1; pending[c] cleared unless recaptured; pointer <= c.
  - No grant: fifo_wrreq <= 0; fifo_data holds its value.
- Latency: acc_valid in cycle t, with credits available and no competition → fifo_wrreq high in cycle t+2. Throughput is 1 word/cycle.
- Credits (width clog2(DEPTH+1)):
  - Decrement on a grant edge.
  - Increment when fifo_rdreq=1 and fifo_empty=0.
  - Both in one cycle: unchanged.
  - rdreq while empty: ignored.
  - Credits never exceed DEPTH; an increment at DEPTH is an assertion failure in simulation.
- fifo_wrreq is never asserted when the FIFO is full. Checkable invariant: credits = DEPTH − words in FIFO.
- overflow bits clear only on reset or clear.

Decomposition:
- Package tracking_iq_pkg holds:
  - field widths ACC_WIDTH and CHAN_WIDTH;
  - field offset constants for ie/ip/il/qe/qp/ql and for the tag;
  - WIDTH derivation.
- The downstream reader uses the same package.
- One sub-module: tracking_rr_arbiter.
  - Inputs: N-bit request, enable, pointer.
  - Outputs: one-hot grant, grant index, valid.
  - Purely combinational.

Test Plan:
- Single dump: acc_valid[2] at t, fields ie..ql = 1..6, FIFO empty → wrreq high only in t+2; fifo_data = {6'd2, 17'd1, 17'd2, 17'd3, 17'd4, 17'd5, 17'd6}; credits 4→3.
- Round-robin: acc_valid on channels 0, 1, 3 simultaneously → tags 0, 1, 3 written in consecutive cycles. A later simultaneous dump on 0 and 5 then writes 5 before 0.
- Credit exhaustion: no reads, dumps on channels 0..4 → exactly 4 writes; pending[4] stays 1. fifo_rdreq=1, empty=0 in cycle r → channel 4 written with wrreq in r+2.
- rdreq with fifo_empty=1 → credits unchanged. rdreq coinciding with a grant → credits unchanged.
- Overflow: credits 0, channel 6 dumps A then B → overflow[6]=1; after one read, the written word carries A. Dump arriving in the same cycle as its slot's grant → no overflow, new data written next.
- Mid-operation clear: 3 pending, credits 1, clear=1 → next cycle fifo_sclr=1, pending=0, overflow=0, wrreq=0; credits=4; subsequent dump written at t+2.

Source files
------------

// File: rtl/tracking_iq_pkg.sv
// rtl/tracking_iq_pkg.sv - shared field layout of tracking I/Q dump words
// Used by tracking_iq_collector and by the downstream tracking_iq_fifo reader.
// Word layout, MSB first: {chan, ie, ip, il, qe, qp, ql}.
package tracking_iq_pkg;

    localparam int ACC_WIDTH  = 17;
    localparam int CHAN_WIDTH = 6;
    localparam int N_FIELDS   = 6;
    localparam int SLOT_WIDTH = N_FIELDS * ACC_WIDTH;
    localparam int WIDTH      = CHAN_WIDTH + SLOT_WIDTH;

    localparam int QL_LSB  = 0 * ACC_WIDTH;
    localparam int QP_LSB  = 1 * ACC_WIDTH;
    localparam int QE_LSB  = 2 * ACC_WIDTH;
    localparam int IL_LSB  = 3 * ACC_WIDTH;
    localparam int IP_LSB  = 4 * ACC_WIDTH;
    localparam int IE_LSB  = 5 * ACC_WIDTH;
    localparam int TAG_LSB = SLOT_WIDTH;

    typedef logic [ACC_WIDTH-1:0]  acc_t;
    typedef logic [CHAN_WIDTH-1:0] chan_t;
    typedef logic [SLOT_WIDTH-1:0] slot_t;
    typedef logic [WIDTH-1:0]      word_t;

    function automatic slot_t pack_slot(acc_t ie, acc_t ip, acc_t il,
                                        acc_t qe, acc_t qp, acc_t ql);
        return {ie, ip, il, qe, qp, ql};
    endfunction

    function automatic word_t pack_word(chan_t chan, slot_t slot);
        return {chan, slot};
    endfunction

    function automatic chan_t word_tag(word_t word);
        return word[TAG_LSB +: CHAN_WIDTH];
    endfunction

endpackage

// File: rtl/tracking_rr_arbiter.sv
// rtl/tracking_rr_arbiter.sv - combinational round-robin request arbiter
// Ports:
//   request   in  N      per-channel request flags
//   enable    in  1      arbitration allowed this cycle
//   pointer   in  IDX_W  last granted index; search starts at pointer+1
//   grant     out N      one-hot grant (all zero when valid=0)
//   grant_idx out IDX_W  index of the granted channel
//   valid     out 1      a grant was issued
module tracking_rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     request,
    input  logic             enable,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        if (enable) begin
            // Walk from the farthest candidate back to pointer+1 so the
            // nearest requester after the pointer is the last to overwrite.
            for (int k = N; k >= 1; k--) begin
                if (request[(int'(pointer) + k) % N]) begin
                    valid     = 1'b1;
                    grant_idx = IDX_W'((int'(pointer) + k) % N);
                end
            end
        end
        if (valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tracking_iq_collector.sv
// rtl/tracking_iq_collector.sv - per-channel I/Q dump capture and tagged FIFO writer
// Ports:
//   clock       in  1                  rising-edge clock
//   reset_n     in  1                  synchronous active-low reset
//   clear       in  1                  synchronous soft clear (tracking restart)
//   acc_valid   in  N_CHANNELS         one-cycle dump strobe per channel
//   acc_data    in  N_CHANNELS*6*ACC   per channel {ie,ip,il,qe,qp,ql}, channel 0 in LSBs
//   fifo_rdreq  in  1                  consumer read request (snooped)
//   fifo_empty  in  1                  FIFO empty flag
//   fifo_wrreq  out 1                  registered FIFO write strobe
//   fifo_data   out WIDTH              registered {chan, ie,ip,il,qe,qp,ql}
//   fifo_sclr   out 1                  registered FIFO synchronous clear
//   pending     out N_CHANNELS         slot-occupied flags
//   overflow    out N_CHANNELS         sticky dropped-dump flags
module tracking_iq_collector
    import tracking_iq_pkg::*;
#(
    parameter int N_CHANNELS = 8,
    parameter int ACC_WIDTH  = tracking_iq_pkg::ACC_WIDTH,
    parameter int CHAN_WIDTH = tracking_iq_pkg::CHAN_WIDTH,
    parameter int WIDTH      = CHAN_WIDTH + N_FIELDS * ACC_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  clear,
    input  logic [N_CHANNELS-1:0]                 acc_valid,
    input  logic [N_CHANNELS*N_FIELDS*ACC_WIDTH-1:0] acc_data,
    input  logic                                  fifo_rdreq,
    input  logic                                  fifo_empty,
    output logic                                  fifo_wrreq,
    output logic [WIDTH-1:0]                      fifo_data,
    output logic                                  fifo_sclr,
    output logic [N_CHANNELS-1:0]                 pending,
    output logic [N_CHANNELS-1:0]                 overflow
);

    localparam int SLOT_W = N_FIELDS * ACC_WIDTH;
    localparam int IDX_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int CRED_W = $clog2(DEPTH + 1);

    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(DEPTH);
    localparam logic [CRED_W-1:0] CRED_ONE  = CRED_W'(1);
    localparam logic [IDX_W-1:0]  PTR_INIT  = IDX_W'(N_CHANNELS - 1);

    logic [SLOT_W-1:0]     slot [N_CHANNELS];
    logic [CRED_W-1:0]     credits;
    logic [IDX_W-1:0]      rr_ptr;
    logic [N_CHANNELS-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  credit_ret;
    logic                  credit_ok;
    logic [N_CHANNELS-1:0] capture;
    logic [N_CHANNELS-1:0] dropped;

    // Credits are the only view of FIFO fullness; a word may be granted only
    // while at least one registered credit remains.
    assign credit_ok  = (credits != '0);
    assign credit_ret = fifo_rdreq & ~fifo_empty;

    tracking_rr_arbiter #(
        .N     (N_CHANNELS),
        .IDX_W (IDX_W)
    ) u_arbiter (
        .request   (pending),
        .enable    (credit_ok),
        .pointer   (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    // A slot being drained this cycle is free to take a new dump; otherwise an
    // occupied slot keeps its old data and the new dump is dropped.
    assign capture = acc_valid & (~pending | grant);
    assign dropped = acc_valid & pending & ~grant;

    always_ff @(posedge clock) begin
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (capture[c]) begin
                slot[c] <= acc_data[c*SLOT_W +: SLOT_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            pending    <= '0;
            overflow   <= '0;
            fifo_wrreq <= 1'b0;
            fifo_data  <= '0;
            fifo_sclr  <= 1'b1;
            credits    <= CRED_FULL;
            rr_ptr     <= PTR_INIT;
        end else begin
            fifo_sclr  <= 1'b0;
            pending    <= (pending & ~grant) | acc_valid;
            overflow   <= overflow | dropped;
            fifo_wrreq <= grant_valid;
            if (grant_valid) begin
                fifo_data <= {CHAN_WIDTH'(grant_idx), slot[grant_idx]};
                rr_ptr    <= grant_idx;
            end
            if (credit_ret && !grant_valid) begin
                credits <= credits + CRED_ONE;
            end else if (!credit_ret && grant_valid) begin
                credits <= credits - CRED_ONE;
            end
        end
    end

    // A read returning a credit while already at DEPTH means the consumer
    // read more words than were ever written.
    always_ff @(posedge clock) begin
        if (reset_n && !clear) begin
            assert (!(credit_ret && !grant_valid && credits == CRED_FULL));
        end
    end

endmodule

// File: tb/tb_tracking_iq_collector.sv
// tb/tb_tracking_iq_collector.sv - self-checking bench for tracking_iq_collector
module tb_tracking_iq_collector;
    import tracking_iq_pkg::*;

    localparam int N  = 8;
    localparam int AW = 17;
    localparam int CW = 6;
    localparam int SW = 6 * AW;
    localparam int W  = CW + SW;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset_n;
    logic            clear;
    logic [N-1:0]    acc_valid;
    logic [N*SW-1:0] acc_data;
    logic            fifo_rdreq;
    logic            fifo_empty;
    logic            force_empty;
    logic            empty_honest;
    logic            fifo_wrreq;
    logic [W-1:0]    fifo_data;
    logic            fifo_sclr;
    logic [N-1:0]    pending;
    logic [N-1:0]    overflow;

    assign fifo_empty = force_empty | empty_honest;

    tracking_iq_collector #(
        .N_CHANNELS (N),
        .ACC_WIDTH  (AW),
        .CHAN_WIDTH (CW),
        .WIDTH      (W),
        .DEPTH      (DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .acc_valid  (acc_valid),
        .acc_data   (acc_data),
        .fifo_rdreq (fifo_rdreq),
        .fifo_empty (fifo_empty),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data),
        .fifo_sclr  (fifo_sclr),
        .pending    (pending),
        .overflow   (overflow)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: slots, flags, credit count (= DEPTH - words held), pointer.
    bit            m_live = 1'b0;
    logic [SW-1:0] m_slot [N];
    logic [N-1:0]  m_pending;
    logic [N-1:0]  m_overflow;
    int            m_credits = DEPTH;
    int            m_ptr;
    bit            m_wrreq;
    logic [W-1:0]  m_data;
    bit            m_sclr;

    always @(posedge clock) begin
        int g;
        if (!reset_n || clear) begin
            m_live     = 1'b1;
            m_pending  = '0;
            m_overflow = '0;
            m_credits  = DEPTH;
            m_ptr      = N - 1;
            m_wrreq    = 1'b0;
            m_data     = '0;
            m_sclr     = 1'b1;
        end else if (m_live) begin
            m_sclr = 1'b0;
            g = -1;
            if (m_credits > 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && m_pending[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            m_wrreq = (g >= 0);
            if (g >= 0) begin
                m_data       = {CW'(g), m_slot[g]};
                m_ptr        = g;
                m_pending[g] = 1'b0;
            end
            for (int c = 0; c < N; c++) begin
                if (acc_valid[c]) begin
                    if (!m_pending[c]) begin
                        m_slot[c]    = acc_data[c*SW +: SW];
                        m_pending[c] = 1'b1;
                    end else begin
                        m_overflow[c] = 1'b1;
                    end
                end
            end
            if (fifo_rdreq && !fifo_empty) m_credits++;
            if (g >= 0) m_credits--;
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            check("cmp_wrreq", W'(fifo_wrreq), W'(m_wrreq));
            check("cmp_data", fifo_data, m_data);
            check("cmp_sclr", W'(fifo_sclr), W'(m_sclr));
            check("cmp_pending", W'(pending), W'(m_pending));
            check("cmp_overflow", W'(overflow), W'(m_overflow));
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
        acc_valid    = '0;
        fifo_rdreq   = 1'b0;
        clear        = 1'b0;
        force_empty  = 1'b0;
        empty_honest = (m_credits == DEPTH);
    endtask

    task automatic dump(int c, logic [SW-1:0] d);
        acc_valid[c]        = 1'b1;
        acc_data[c*SW +: SW] = d;
    endtask

    logic [SW-1:0] da, db, dc, dd;
    int writes;

    initial begin
        reset_n = 1'b0; clear = 1'b0; acc_valid = '0; acc_data = '0;
        fifo_rdreq = 1'b0; force_empty = 1'b0; empty_honest = 1'b1;
        step();
        check("rst_pending", W'(pending), '0);
        check("rst_overflow", W'(overflow), '0);
        check("rst_wrreq", W'(fifo_wrreq), '0);
        check("rst_data", fifo_data, '0);
        check("rst_sclr", W'(fifo_sclr), W'(1));
        reset_n = 1'b1;
        step();
        check("rst_sclr_drop", W'(fifo_sclr), '0);

        // single dump on channel 2
        dump(2, pack_slot(17'd1, 17'd2, 17'd3, 17'd4, 17'd5, 17'd6));
        step();
        check("single_t1_wrreq", W'(fifo_wrreq), '0);
        step();
        check("single_t2_wrreq", W'(fifo_wrreq), W'(1));
        check("single_t2_data", fifo_data,
              {6'd2, 17'd1, 17'd2, 17'd3, 17'd4, 17'd5, 17'd6});
        step();
        check("single_t3_wrreq", W'(fifo_wrreq), '0);
        check("single_credits", W'(m_credits), W'(3));
        fifo_rdreq = 1'b1;
        step();

        // round robin
        clear = 1'b1;
        step();
        acc_valid = 8'b0000_1011;
        step();
        step();
        check("rr_tag0", W'(word_tag(fifo_data)), W'(0));
        step();
        check("rr_tag1", W'(word_tag(fifo_data)), W'(1));
        step();
        check("rr_tag3", W'(word_tag(fifo_data)), W'(3));
        for (int i = 0; i < 3; i++) begin
            fifo_rdreq = 1'b1;
            step();
        end
        dump(0, '0);
        dump(5, '1);
        step();
        step();
        check("rr_tag5_first", W'(word_tag(fifo_data)), W'(5));
        step();
        check("rr_tag0_second", W'(word_tag(fifo_data)), W'(0));

        // credit exhaustion
        clear = 1'b1;
        step();
        acc_valid = 8'b0001_1111;
        step();
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (fifo_wrreq) writes++;
        end
        check("exhaust_writes", W'(writes), W'(4));
        check("exhaust_pending", W'(pending), W'(8'h10));
        fifo_rdreq = 1'b1;
        step();
        check("exhaust_r1_wrreq", W'(fifo_wrreq), '0);
        step();
        check("exhaust_r2_wrreq", W'(fifo_wrreq), W'(1));
        check("exhaust_r2_tag", W'(word_tag(fifo_data)), W'(4));

        // rdreq while empty is ignored; rdreq alongside a grant nets zero
        fifo_rdreq = 1'b1; force_empty = 1'b1;
        step();
        check("empty_rd_credits", W'(m_credits), '0);
        dump(0, pack_slot(17'd7, 17'd7, 17'd7, 17'd7, 17'd7, 17'd7));
        for (int i = 0; i < 3; i++) step();
        check("empty_rd_no_write", W'(fifo_wrreq), '0);
        fifo_rdreq = 1'b1;
        step();
        fifo_rdreq = 1'b1;
        step();
        check("coincide_wrreq", W'(fifo_wrreq), W'(1));
        check("coincide_credits", W'(m_credits), W'(1));
        dump(1, '0);
        step();
        step();
        check("coincide_credit_used", W'(fifo_wrreq), W'(1));

        // overflow keeps the first dump
        da = pack_slot(17'd11, 17'd12, 17'd13, 17'd14, 17'd15, 17'd16);
        db = pack_slot(17'd21, 17'd22, 17'd23, 17'd24, 17'd25, 17'd26);
        dump(6, da);
        step();
        dump(6, db);
        step();
        check("ovf_flag", W'(overflow), W'(8'h40));
        fifo_rdreq = 1'b1;
        step();
        step();
        check("ovf_keeps_a", fifo_data, {6'd6, da});

        // dump in the same cycle its slot is granted
        clear = 1'b1;
        step();
        dc = pack_slot(17'd31, 17'd32, 17'd33, 17'd34, 17'd35, 17'd36);
        dd = pack_slot(17'd41, 17'd42, 17'd43, 17'd44, 17'd45, 17'd46);
        dump(1, dc);
        step();
        dump(1, dd);
        step();
        check("regrant_first", fifo_data, {6'd1, dc});
        check("regrant_no_ovf", W'(overflow), '0);
        step();
        check("regrant_second", fifo_data, {6'd1, dd});
        check("regrant_wrreq", W'(fifo_wrreq), W'(1));

        // clear in the middle of draining
        clear = 1'b1;
        step();
        acc_valid = 8'h3f;
        step();
        dump(5, '1);
        step();
        step();
        step();
        check("midclr_pending", W'(pending), W'(8'h38));
        check("midclr_credits", W'(m_credits), W'(1));
        check("midclr_ovf", W'(overflow), W'(8'h20));
        clear = 1'b1;
        step();
        check("midclr_sclr", W'(fifo_sclr), W'(1));
        check("midclr_pending0", W'(pending), '0);
        check("midclr_ovf0", W'(overflow), '0);
        check("midclr_wrreq0", W'(fifo_wrreq), '0);
        check("midclr_credits4", W'(m_credits), W'(4));
        dump(7, '0);
        step();
        step();
        check("midclr_after_wrreq", W'(fifo_wrreq), W'(1));
        check("midclr_after_tag", W'(word_tag(fifo_data)), W'(7));

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    dump(c, SW'({$urandom(), $urandom(), $urandom(), $urandom()}));
                end
            end
            fifo_rdreq  = ($urandom_range(0, 2) != 0);
            force_empty = ($urandom_range(0, 9) == 0);
            clear       = ($urandom_range(0, 299) == 0);
            reset_n     = ($urandom_range(0, 499) != 0);
            step();
        end
        reset_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
